// File: rtl/dmem_pkg.sv
// Shared sizes and FSM encoding for the data-memory arbiter.
package dmem_pkg;

    localparam int DMEM_DEPTH  = 32;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the requester that
// did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    assign grant_valid = req0 | req1;
    assign grant_idx   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sequencer between two requesters and the data memory.
// Strobes are registered and live for exactly one ACCESS cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(DEPTH);

    state_t r_state;
    logic   r_last_grant;
    logic   r_sel;
    logic   r_we;
    logic   r_oor;

    logic              w_valid;
    logic              w_idx;
    logic              w_we;
    logic              w_oor;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    rr_arb2 u_arb (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (r_last_grant),
        .grant_valid (w_valid),
        .grant_idx   (w_idx)
    );

    assign w_we    = w_idx ? we1    : we0;
    assign w_addr  = w_idx ? addr1  : addr0;
    assign w_wdata = w_idx ? wdata1 : wdata0;
    // Full-width compare so high address bits can never alias in range
    assign w_oor   = (w_addr >= LP_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_sel        <= 1'b0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
        end else begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_sel     <= w_idx;
                        r_we      <= w_we;
                        r_oor     <= w_oor;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        mem_read  <= !w_we && !w_oor;
                        mem_write <= w_we && !w_oor;
                        if (req0 && req1)
                            r_last_grant <= w_idx;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we)
                        rdata <= r_oor ? '0 : mem_rdata;
                    ack0    <= !r_sel;
                    ack1    <= r_sel;
                    err0    <= !r_sel && r_oor;
                    err1    <= r_sel && r_oor;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 32-word data memory.
- Requesters (e.g. CPU datapath and a DMA/accumulate engine) issue single-word read/write transactions with a req/ack handshake.
- The block grants round-robin, drives the memory's address/data/MemRead/MemWrite for exactly one cycle per transaction, registers read data and returns it with an ack pulse.
- The memory strobes are level-sensitive, so this block guarantees they are never left asserted.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width; value is a word index.
- DEPTH, 32, number of valid memory words; addresses >= DEPTH are rejected.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-low reset.
- req0, req1  in  1  transaction request; held high until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req high.
- addr0, addr1  in  ADDR_W  word address; stable while req high.
- wdata0, wdata1  in  DATA_W  write data; stable while req high.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  one-cycle pulse coincident with ack; address out of range.
- rdata  out  DATA_W  registered read data; valid in the ack cycle; holds value otherwise.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory WriteData.
- mem_read, mem_write  out  1  to memory MemRead/MemWrite.
- mem_rdata  in  DATA_W  from memory ReadData.

Behaviour:
- Reset (rst = 0 at a rising edge):
  - state = IDLE; last_grant = 1, so requester 0 wins first.
  - ack*, err*, mem_read, mem_write = 0; rdata, mem_addr, mem_wdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE; all strobes 0.
  - One req: latch its index into sel and register addr/we/wdata into mem_addr/mem_wdata; go to ACCESS.
  - Both req: select the requester != last_grant; set last_grant = sel.
- ACCESS (exactly one cycle):
  - addr < DEPTH: mem_read = !we or mem_write = we.
  - Read: capture mem_rdata into rdata at the end of this cycle.
  - addr >= DEPTH: both strobes stay 0, memory is untouched, err flagged.
  - Go to RESP.
- RESP:
  - ack[sel] = 1; err[sel] = 1 if out of range; strobes 0.
  - Error reads return rdata = 0.
  - Go to IDLE.
- Latency: req sampled high in IDLE at cycle N; strobe in N+1; ack in N+2. Back-to-back service gives one transaction per 3 cycles.
- mem_read and mem_write are never both 1 and are only ever high in ACCESS. mem_addr is held after ACCESS so the memory never sees an address change with a strobe high.
- Handshake rules:
  - A requester drops req in the cycle after ack. If req is still high in the IDLE cycle after ack, it is a new transaction.
  - req dropped before ack is a protocol violation; the in-flight access still completes and acks.
- Fairness: with both req held continuously, grants strictly alternate 0,1,0,1… No requester waits more than one transaction.
- Reset mid-operation: rst = 0 in ACCESS or RESP aborts the transaction. Strobes are 0 after that edge, no ack is issued, and last_grant returns to 1. A write strobed in the same cycle may already have landed in memory; this is accepted.
- Width rule: the range check compares the full ADDR_W address against DEPTH; no truncation.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, ACCESS, RESP} (2-bit).
  - DMEM_DEPTH = 32, DMEM_DATA_W = 32, DMEM_ADDR_W = 32.
- Sub-module rr_arb2 (combinational): inputs req0, req1, last_grant; outputs grant_valid, grant_idx. dmem_arbiter owns the FSM and the last_grant register.

Test Plan:
- Reset, then req0 read addr 3 with memory preloaded 10,20,…,100 -> mem_read high in cycle N+1 only; ack0 and rdata = 40 in N+2; ack1 never set.
- req0 and req1 both reading, held continuously -> grant order 0,1,0,1; ack0 and ack1 pulses alternate, 3 cycles apart.
- req1 writes 123 to addr 5, then req0 reads addr 5 -> mem_write one cycle with mem_wdata = 123; req0 read returns 123.
- req0 read addr 40 -> no mem_read/mem_write pulse; ack0 = err0 = 1, rdata = 0; memory contents unchanged.
- req1 reads addr 0..9 in sequence, accumulating in the bench -> sum = 550; each access takes 3 cycles.
- rst = 0 during ACCESS of a req0 read -> next cycle IDLE, strobes 0, no ack0; after release, simultaneous req0/req1 grants req0 first.
